// File: rtl/cac_fns_pkg.sv
// Shared Fibonacci-numeral-system helpers for the FTF crosstalk-avoidance coders.
// All functions are constant-foldable so they can size ports and build weight tables.
package cac_fns_pkg;

  localparam int MAX_WIRE = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    DONE = 2'd2
  } enc_state_t;

  // fib(0)=0, fib(1)=fib(2)=1
  function automatic int fib(input int n);
    int a, b, t;
    a = 0;
    b = 1;
    for (int i = 0; i < n; i++) begin
      t = a + b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  function automatic int fns_weight(input int k);
    return fib(k + 2);
  endfunction

  // pol=0 sets the odd bits, pol=1 the even bits, within the low n bits only
  function automatic logic [MAX_WIRE-1:0] ftf_mask(input int n, input logic pol);
    logic [MAX_WIRE-1:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[j] = ((j % 2) == 1) ^ pol;
    return m;
  endfunction

  // A codeword is legal when its unmasked digit vector has no two adjacent ones.
  function automatic logic ftf_legal(input logic [MAX_WIRE-1:0] code, input int n,
                                     input logic pol);
    logic [MAX_WIRE-1:0] z;
    z = code ^ ftf_mask(n, pol);
    return ((z & (z >> 1)) == '0);
  endfunction

endpackage

// File: rtl/cac_fns_greedy_step.sv
// One greedy Zeckendorf digit: take the weight if the remainder still covers it.
module cac_fns_greedy_step #(
  parameter int W = 6
) (
  input  logic [W-1:0] rem_i,
  input  logic [W-1:0] weight_i,
  output logic         digit_o,
  output logic [W-1:0] rem_next_o
);

  assign digit_o    = (rem_i >= weight_i);
  assign rem_next_o = digit_o ? (rem_i - weight_i) : rem_i;

endmodule

// File: rtl/cac_ftf_enc_seq.sv
// Sequential FNS encoder: greedy MSB-first digit per cycle, then FTF polarity mask.
// The codeword register only updates on entry to DONE, so TSVs see one clean transition.
module cac_ftf_enc_seq
  import cac_fns_pkg::*;
#(
  parameter  int N_WIRE = 8,
  localparam int DATA_W = $clog2(fib(N_WIRE + 2))
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_pol,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N_WIRE-1:0] out_code,
  output logic              out_err
);

  localparam int                KW    = $clog2(N_WIRE);
  localparam logic [DATA_W:0]   LIMIT = (DATA_W + 1)'(fib(N_WIRE + 2));
  localparam logic [N_WIRE-1:0] MASK0 = N_WIRE'(ftf_mask(N_WIRE, 1'b0));
  localparam logic [N_WIRE-1:0] MASK1 = ~MASK0;

  enc_state_t        state_q, state_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [N_WIRE-1:0] z_q, z_d, z_fin;
  logic [KW-1:0]     k_q, k_d;
  logic              pol_q, pol_d;
  logic [N_WIRE-1:0] code_q, code_d;
  logic              err_q, err_d;

  logic [N_WIRE-1:0][DATA_W-1:0] wts;
  logic                          digit;
  logic [DATA_W-1:0]             rem_nxt;

  for (genvar g = 0; g < N_WIRE; g++) begin : g_wt
    assign wts[g] = DATA_W'(fns_weight(g));
  end

  cac_fns_greedy_step #(.W(DATA_W)) u_step (
    .rem_i      (rem_q),
    .weight_i   (wts[k_q]),
    .digit_o    (digit),
    .rem_next_o (rem_nxt)
  );

  always_comb begin
    z_fin        = z_q;
    z_fin[k_q]   = digit;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    z_d     = z_q;
    k_d     = k_q;
    pol_d   = pol_q;
    code_d  = code_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          pol_d = in_pol;
          // Out-of-range words skip encoding; the previous codeword stays on the wires.
          if ({1'b0, in_data} >= LIMIT) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            rem_d   = in_data;
            z_d     = '0;
            k_d     = KW'(N_WIRE - 1);
            state_d = ENC;
          end
        end
      end
      ENC: begin
        z_d   = z_fin;
        rem_d = rem_nxt;
        if (k_q == '0) begin
          state_d = DONE;
          code_d  = z_fin ^ (pol_q ? MASK1 : MASK0);
        end else begin
          k_d = k_q - KW'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      z_q     <= '0;
      k_q     <= '0;
      pol_q   <= 1'b0;
      code_q  <= MASK0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      z_q     <= z_d;
      k_q     <= k_d;
      pol_q   <= pol_d;
      code_q  <= code_d;
      err_q   <= err_d;
    end
  end

  assign in_ready  = (state_q == IDLE) & ~reset;
  assign out_valid = (state_q == DONE) & ~reset;
  assign out_err   = err_q & ~reset;
  assign out_code  = code_q;

`ifndef SYNTHESIS
  // A legal input is always fully consumed by the last digit.
  always_ff @(posedge clock) begin
    if (!reset && state_q == ENC && k_q == '0) assert (rem_nxt == '0);
  end
`endif

endmodule

// File: tb/tb_cac_ftf_enc_seq.sv
// Bench for cac_ftf_enc_seq: three widths (5, 8, 12 wires) against an integer Zeckendorf model.
module tb_cac_ftf_enc_seq;
  import cac_fns_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [2:0]  iv, ipol, ordy, ir, ov, oe;
  logic [15:0] idata [3];
  logic [23:0] oc    [3];

  int n_checks = 0;
  int n_pass   = 0;

  function automatic int nw(input int g);
    return (g == 0) ? 5 : ((g == 1) ? 8 : 12);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int N  = nw(g);
    localparam int DW = $clog2(fib(N + 2));
    logic [N-1:0] c;
    cac_ftf_enc_seq #(.N_WIRE(N)) u_dut (
      .clock     (clk),
      .reset     (rst),
      .in_valid  (iv[g]),
      .in_ready  (ir[g]),
      .in_data   (idata[g][DW-1:0]),
      .in_pol    (ipol[g]),
      .out_valid (ov[g]),
      .out_ready (ordy[g]),
      .out_code  (c),
      .out_err   (oe[g])
    );
    assign oc[g] = 24'(c);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [23:0] tb_mask(input int n, input bit pol);
    logic [23:0] m;
    m = '0;
    for (int j = 0; j < n; j++) m[j] = ((j % 2) == 1) ? ~pol : pol;
    return m;
  endfunction

  // Zeckendorf digits of data (largest Fibonacci weight first), then the polarity mask
  function automatic logic [23:0] ref_code(input int n, input int data, input bit pol);
    logic [23:0] z;
    int r;
    z = '0;
    r = data;
    for (int k = n - 1; k >= 0; k--) begin
      if (r >= fib(k + 2)) begin
        z[k] = 1'b1;
        r    = r - fib(k + 2);
      end
    end
    return z ^ tb_mask(n, pol);
  endfunction

  function automatic int decode(input int n, input logic [23:0] code, input bit pol);
    logic [23:0] z;
    int s;
    z = code ^ tb_mask(n, pol);
    s = 0;
    for (int k = 0; k < n; k++) if (z[k]) s += fib(k + 2);
    return s;
  endfunction

  // One full word: accept, wait for out_valid, handshake. lat counts edges including accept.
  task automatic xact(input int g, input int data, input bit pol, output int lat,
                      output logic [23:0] code, output logic err);
    lat  = -1;
    code = 'x;
    err  = 1'bx;
    for (int i = 0; i < 50 && ir[g] !== 1'b1; i++) tick;
    if (ir[g] !== 1'b1) return;
    iv[g]    = 1'b1;
    idata[g] = 16'(data);
    ipol[g]  = pol;
    tick;
    iv[g]    = 1'b0;
    ipol[g]  = ~pol;
    idata[g] = 16'($urandom);
    lat = 1;
    while (ov[g] !== 1'b1 && lat < 100) begin
      tick;
      lat++;
    end
    if (ov[g] !== 1'b1) begin
      lat = -1;
      return;
    end
    code    = oc[g];
    err     = oe[g];
    ordy[g] = 1'b1;
    tick;
    ordy[g] = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; iv = '0; ipol = '0; ordy = '0;
    for (int g = 0; g < 3; g++) idata[g] = '0;
    tick; tick;
    n_checks++; if (ir[1] !== 1'b0) $display("FAIL rst_in_ready got %b exp 0", ir[1]); else n_pass++;
    n_checks++; if (ov[1] !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", ov[1]); else n_pass++;
    n_checks++; if (oe[1] !== 1'b0) $display("FAIL rst_out_err got %b exp 0", oe[1]); else n_pass++;
    n_checks++; if (oc[1] !== 24'hAA) $display("FAIL rst_out_code got %h exp aa", oc[1]); else n_pass++;
    rst = 1'b0;
    #1;
    n_checks++; if (ir[1] !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", ir[1]); else n_pass++;
  endtask

  task automatic test_vectors;
    int          d  [6] = '{0, 54, 54, 20, 20, 7};
    bit          p  [6] = '{0, 0, 1, 0, 1, 1};
    logic [23:0] ex [6] = '{24'hAA, 24'h00, 24'hFF, 24'h80, 24'h7F, 24'h5F};
    int lat; logic [23:0] c; logic e;
    for (int i = 0; i < 6; i++) begin
      xact(1, d[i], p[i], lat, c, e);
      n_checks++; if (c !== ex[i]) $display("FAIL vec_code d=%0d p=%0d got %h exp %h", d[i], p[i], c, ex[i]); else n_pass++;
      n_checks++; if (e !== 1'b0) $display("FAIL vec_err d=%0d got %b exp 0", d[i], e); else n_pass++;
      n_checks++; if (lat !== 9) $display("FAIL vec_latency d=%0d got %0d exp 9", d[i], lat); else n_pass++;
    end
  endtask

  task automatic test_error;
    int lat; logic [23:0] c; logic e;
    xact(1, 20, 0, lat, c, e);
    n_checks++; if (c !== 24'h80) $display("FAIL err_prior_code got %h exp 80", c); else n_pass++;
    xact(1, 55, 0, lat, c, e);
    n_checks++; if (e !== 1'b1) $display("FAIL err_flag_55 got %b exp 1", e); else n_pass++;
    n_checks++; if (c !== 24'h80) $display("FAIL err_code_held_55 got %h exp 80", c); else n_pass++;
    n_checks++; if (lat !== 1) $display("FAIL err_latency_55 got %0d exp 1", lat); else n_pass++;
    xact(1, 63, 1, lat, c, e);
    n_checks++; if (e !== 1'b1) $display("FAIL err_flag_63 got %b exp 1", e); else n_pass++;
    n_checks++; if (c !== 24'h80) $display("FAIL err_code_held_63 got %h exp 80", c); else n_pass++;
    xact(1, 3, 1, lat, c, e);
    n_checks++; if (e !== 1'b0) $display("FAIL err_clear_next got %b exp 0", e); else n_pass++;
    n_checks++; if (c !== 24'h51) $display("FAIL err_next_code got %h exp 51", c); else n_pass++;
    n_checks++; if (ir[1] !== 1'b1) $display("FAIL back_to_back_ready got %b exp 1", ir[1]); else n_pass++;
  endtask

  task automatic test_backpressure;
    logic [23:0] c0;
    int t;
    for (int i = 0; i < 50 && ir[1] !== 1'b1; i++) tick;
    iv[1] = 1'b1; idata[1] = 16'd33; ipol[1] = 1'b0;
    tick;
    iv[1] = 1'b0;
    for (t = 1; t < 100 && ov[1] !== 1'b1; t++) tick;
    n_checks++; if (ov[1] !== 1'b1) $display("FAIL bp_valid_timeout got %b exp 1", ov[1]); else n_pass++;
    c0 = oc[1];
    n_checks++; if (c0 !== 24'hFF) $display("FAIL bp_code got %h exp ff", c0); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      tick;
      n_checks++; if (ov[1] !== 1'b1) $display("FAIL bp_valid_hold cyc=%0d got %b exp 1", i, ov[1]); else n_pass++;
      n_checks++; if (oc[1] !== c0) $display("FAIL bp_code_hold cyc=%0d got %h exp %h", i, oc[1], c0); else n_pass++;
      n_checks++; if (oe[1] !== 1'b0) $display("FAIL bp_err_hold cyc=%0d got %b exp 0", i, oe[1]); else n_pass++;
      n_checks++; if (ir[1] !== 1'b0) $display("FAIL bp_ready_low cyc=%0d got %b exp 0", i, ir[1]); else n_pass++;
    end
    ordy[1] = 1'b1;
    tick;
    ordy[1] = 1'b0;
    n_checks++; if (ov[1] !== 1'b0) $display("FAIL bp_valid_drop got %b exp 0", ov[1]); else n_pass++;
    n_checks++; if (ir[1] !== 1'b1) $display("FAIL bp_ready_back got %b exp 1", ir[1]); else n_pass++;
  endtask

  // out_ready held high through ENC, in_valid dropped and in_pol flipped mid-word
  task automatic test_mid_word;
    int lat;
    ordy[1] = 1'b1;
    for (int i = 0; i < 50 && ir[1] !== 1'b1; i++) tick;
    iv[1] = 1'b1; idata[1] = 16'd12; ipol[1] = 1'b1;
    tick;
    iv[1] = 1'b0; ipol[1] = 1'b0; idata[1] = 16'd50;
    for (lat = 1; lat < 100 && ov[1] !== 1'b1; lat++) tick;
    n_checks++; if (lat !== 9) $display("FAIL mid_latency got %0d exp 9", lat); else n_pass++;
    n_checks++; if (oc[1] !== 24'h40) $display("FAIL mid_code got %h exp 40", oc[1]); else n_pass++;
    tick;
    ordy[1] = 1'b0;
    n_checks++; if (ov[1] !== 1'b0) $display("FAIL mid_handshake got %b exp 0", ov[1]); else n_pass++;
  endtask

  task automatic test_reset_mid;
    int lat; logic [23:0] c; logic e;
    xact(1, 54, 1, lat, c, e);
    n_checks++; if (c !== 24'hFF) $display("FAIL rmid_prior_code got %h exp ff", c); else n_pass++;
    iv[1] = 1'b1; idata[1] = 16'd40; ipol[1] = 1'b0;
    tick;
    iv[1] = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    n_checks++; if (ov[1] !== 1'b0) $display("FAIL rmid_valid got %b exp 0", ov[1]); else n_pass++;
    n_checks++; if (oc[1] !== 24'hAA) $display("FAIL rmid_code got %h exp aa", oc[1]); else n_pass++;
    n_checks++; if (ir[1] !== 1'b1) $display("FAIL rmid_ready got %b exp 1", ir[1]); else n_pass++;
    xact(1, 40, 0, lat, c, e);
    n_checks++; if (c !== 24'h23) $display("FAIL rmid_after_code got %h exp 23", c); else n_pass++;
  endtask

  task automatic test_random;
    int lat, d; bit p; logic [23:0] c, prev, exp_c; logic e;
    xact(1, 1, 0, lat, prev, e);
    for (int i = 0; i < 30; i++) begin
      d = int'($urandom_range(0, 63));
      p = 1'($urandom);
      xact(1, d, p, lat, c, e);
      exp_c = (d >= 55) ? prev : ref_code(8, d, p);
      n_checks++; if (c !== exp_c) $display("FAIL rand_code d=%0d p=%0d got %h exp %h", d, p, c, exp_c); else n_pass++;
      n_checks++; if (e !== (d >= 55)) $display("FAIL rand_err d=%0d got %b exp %b", d, e, (d >= 55)); else n_pass++;
      n_checks++; if (lat !== ((d >= 55) ? 1 : 9)) $display("FAIL rand_latency d=%0d got %0d", d, lat); else n_pass++;
      prev = exp_c;
    end
  endtask

  task automatic test_sweep;
    int lat, n, lim; logic [23:0] c, z; logic e;
    for (int g = 0; g < 3; g++) begin
      n   = nw(g);
      lim = fib(n + 2);
      for (int p = 0; p < 2; p++) begin
        for (int d = 0; d < lim; d++) begin
          xact(g, d, p[0], lat, c, e);
          z = c ^ tb_mask(n, p[0]);
          n_checks++; if (c !== ref_code(n, d, p[0])) $display("FAIL sweep_code n=%0d d=%0d p=%0d got %h exp %h", n, d, p, c, ref_code(n, d, p[0])); else n_pass++;
          n_checks++; if (decode(n, c, p[0]) !== d) $display("FAIL sweep_decode n=%0d d=%0d got %0d", n, d, decode(n, c, p[0])); else n_pass++;
          n_checks++; if ((z & (z >> 1)) !== 24'h0 || !ftf_legal(c, n, p[0])) $display("FAIL sweep_ftf n=%0d d=%0d code %h", n, d, c); else n_pass++;
          n_checks++; if (e !== 1'b0) $display("FAIL sweep_err n=%0d d=%0d got %b exp 0", n, d, e); else n_pass++;
          n_checks++; if (lat !== n + 1) $display("FAIL sweep_latency n=%0d d=%0d got %0d exp %0d", n, d, lat, n + 1); else n_pass++;
        end
      end
      xact(g, lim, 0, lat, c, e);
      n_checks++; if (e !== 1'b1) $display("FAIL sweep_range_err n=%0d got %b exp 1", n, e); else n_pass++;
      n_checks++; if (lat !== 1) $display("FAIL sweep_range_latency n=%0d got %0d exp 1", n, lat); else n_pass++;
    end
  endtask

  initial begin
    test_reset;
    test_vectors;
    test_error;
    test_backpressure;
    test_mid_word;
    test_reset_mid;
    test_random;
    test_sweep;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired after %0d checks", n_checks);
    $fatal(1);
  end

endmodule

// File: doc/cac_ftf_enc_seq.md
Name: cac_ftf_enc_seq

Overview:
- Parametrised sequential Fibonacci-numeral-system (FNS) crosstalk-avoidance encoder for an N_WIRE-wide TSV bundle. It is the successor to the fixed 8-wire CAC coder.
- Converts a binary word to a Zeckendorf digit vector by greedy subtraction, MSB first, one digit per cycle.
- XORs the digit vector with a selectable FTF polarity mask, giving a forbidden-transition-free codeword.
- Sits between the data source and the TSV drivers. Valid/ready handshakes on both sides; the codeword is held stable between commits.

Parameters:
- N_WIRE, 8, number of TSV wires (codeword bits); legal range 3..24.
- DATA_W, $clog2(fib(N_WIRE+2)) (6 for N_WIRE=8), input width. Derived localparam, not overridable.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  source offers in_data/in_pol.
- in_ready  out  1  encoder can accept.
- in_data  in  DATA_W  binary value to encode.
- in_pol  in  1  FTF polarity: 0 = mask odd bits (…1010), 1 = mask even bits (…0101).
- out_valid  out  1  codeword/err valid.
- out_ready  in  1  sink accepts.
- out_code  out  N_WIRE  FTF codeword, drives TSVs.
- out_err  out  1  input out of range for this word.

Behaviour:
- Clock and reset:
  - One clock domain. Reset is synchronous and active-high; it has priority over every other event.
- Reset values:
  - out_valid=0, out_err=0, in_ready=0 during the reset cycle.
  - out_code=MASK0 (0xAA for N_WIRE=8), the codeword of value 0 with pol 0.
  - State=IDLE; rem, z and k are cleared.
- Weights and masks:
  - Weights w[k]=fib(k+2), fib(1)=fib(2)=1. For N_WIRE=8: w0..w7 = 1,2,3,5,8,13,21,34.
  - Legal input range is 0..fib(N_WIRE+2)-1, i.e. 0..54 for N_WIRE=8.
  - MASK0 bit j = 1 for odd j. MASK1 = ~MASK0.
- FSM state IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch pol.
  - If in_data >= fib(N_WIRE+2): latch err=1, go to DONE.
  - Otherwise: rem=in_data, z=0, k=N_WIRE-1, go to ENC.
- FSM state ENC, one digit per edge:
  - If rem >= w[k]: z[k]=1, rem=rem-w[k]; else z[k]=0.
  - When k==0, go to DONE and register out_code = z_final ^ MASK[pol] on that same edge. Otherwise k=k-1.
  - Greedy order guarantees no adjacent ones in z, hence no forbidden transition in out_code.
  - rem==0 at exit: design assertion.
- FSM state DONE:
  - out_valid=1. out_valid, out_code and out_err are held until out_valid&out_ready; then go to IDLE and clear out_valid and out_err on that edge.
- Error word:
  - out_code keeps its previous value; out_err=1 for that word only.
- Latency:
  - Accept edge t0. Legal word: out_valid rises after edge t0+N_WIRE (9 edges for N_WIRE=8). Error word: out_valid rises after edge t0+1.
- Throughput and stability:
  - One word per N_WIRE+2 cycles with no backpressure.
  - in_ready=0 in ENC and DONE; there is no overlap of successive words.
  - out_code changes only on the edge entering DONE, so there are no intermediate toggles on the TSVs.
- Boundary cases:
  - Back-to-back words: in_ready reasserts one cycle after the out handshake.
  - in_valid deasserted mid-ENC: ignored, because data was latched at accept.
  - in_pol change mid-ENC: ignored.
  - reset mid-ENC or mid-DONE: the partial word is discarded and the reset values apply on the next cycle.
  - out_ready high while not in DONE: no effect.

Decomposition:
- Package cac_fns_pkg contains:
  - function fib(int n), usable in constant expressions;
  - function fns_weight(k);
  - function ftf_mask(N, pol);
  - enum enc_state_t {IDLE, ENC, DONE};
  - function ftf_legal(code, pol) for benches and assertions.
- One combinational sub-module, cac_fns_greedy_step: (rem, weight) -> (digit, rem_next).

Test Plan:
- N_WIRE=8, pol=0, data 0 -> z=0x00, out_code=0xAA, out_err=0. out_valid rises 9 edges after accept.
- data 54: z=0xAA (34+13+5+2). pol=0 -> out_code=0x00; pol=1 -> out_code=0xFF.
- data 20, pol=0: z=0x2A (13+5+2) -> out_code=0x80. Same data, pol=1 -> 0x7F.
- data 55 after a prior word of 0x80 -> out_valid after 1 edge, out_err=1, out_code stays 0x80. Next legal word has out_err=0.
- Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid, out_code and out_err stable, in_ready=0. Handshake on cycle 6 -> IDLE, in_ready=1 on the next cycle.
- Reset asserted on the 4th ENC cycle -> next cycle out_valid=0, out_code=0xAA, in_ready=1 one cycle after reset deasserts.
- Sweep 0..54 for both pols and N_WIRE in {5,8,12}. Every out_code must satisfy:
  - ftf_legal(out_code, pol);
  - sum of w[k]·(out_code^MASK[pol])[k] equals the input.
